// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses digits above the highest nonzero one.
//
// state   | meaning
// S_IDLE  | no value loaded yet; all anodes off, seg_out cleared
// S_BLANK | all anodes off while bcd_out settles through the shared decoder
// S_DRIVE | anode of digit idx low, latched segments shown
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int SLOT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W    = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_DASH   = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    done_q, done_d;

  logic [3:0]              cur_digit;
  logic                    suppress;

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = active_q[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] lead_hi;

  // Digit 0 is never suppressed because lead_hi bottoms out at index 0.
  always_comb begin
    lead_hi = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (active_q[4*i +: 4] != 4'd0) lead_hi = IDX_W'(i);
    end
  end

  assign suppress = (idx_q > lead_hi);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    seg_d    = seg_q;
    an_d     = '1;
    done_d   = 1'b0;

    if (load) shadow_d = digits_in;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d  = S_BLANK;
          idx_d    = '0;
          cnt_d    = BLANK_LOAD;
          active_d = digits_in;
        end
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          cnt_d   = DRIVE_LOAD;
          if (suppress)            seg_d = 7'b0000000;
          else if (cur_digit > 4'd9) seg_d = SEG_DASH;
          else                     seg_d = seg_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = S_BLANK;
          cnt_d   = BLANK_LOAD;
          // Pending loads only take effect here, so a frame never mixes two values.
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            active_d = shadow_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so they line up with state_q.
    if ((state_d == S_DRIVE) && !suppress) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_d != IDX_W'(i));
      end
    end
    done_d = (state_d == S_DRIVE) && (cnt_d == '0) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= '0;
      an_q     <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      done_q   <= done_d;
    end
  end

  assign bcd_out    = cur_digit;
  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = done_q;

endmodule
